// File: rtl/imem_loader_if.sv
// Byte-stream and instruction-RAM write-port bundle for the instruction memory loader.
// The master side feeds the byte stream; the slave side (the loader) drives the RAM write port and status.
interface imem_loader_if #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
);
  localparam int AW = $clog2(TAM_POSICIONES);

  logic                   START;
  logic [7:0]             BYTE_IN;
  logic                   BYTE_VALID;
  logic                   BYTE_READY;
  logic                   WR_EN;
  logic [AW-1:0]          WR_ADDRESS;
  logic [TAM_PALABRA-1:0] WR_DATA;
  logic                   BUSY;
  logic                   DONE;
  logic                   ERROR;

  modport master (
    output START, BYTE_IN, BYTE_VALID,
    input  BYTE_READY, WR_EN, WR_ADDRESS, WR_DATA, BUSY, DONE, ERROR
  );

  modport slave (
    input  START, BYTE_IN, BYTE_VALID,
    output BYTE_READY, WR_EN, WR_ADDRESS, WR_DATA, BUSY, DONE, ERROR
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into the instruction RAM, one word per write cycle.
// Stream: 16-bit word count N (LSB first), then N words of TAM_PALABRA/8 bytes each.
module imem_loader #(
  parameter int TAM_POSICIONES = 1024,
  parameter int TAM_PALABRA    = 32
) (
  input  logic         CLK,
  input  logic         RESET,
  imem_loader_if.slave bus
);
  localparam int BYTES = TAM_PALABRA / 8;
  localparam int AW    = $clog2(TAM_POSICIONES);
  localparam int IW    = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [16:0]   MAX_N    = 17'(TAM_POSICIONES);
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_LO,
    S_LEN_HI,
    S_CHECK,
    S_DATA,
    S_WRITE,
    S_FINISH,
    S_ERR
  } state_t;

  function automatic logic [TAM_PALABRA-1:0] put_byte(
    input logic [TAM_PALABRA-1:0] word,
    input logic [IW-1:0]          lane,
    input logic [7:0]             data
  );
    logic [TAM_PALABRA-1:0] res;
    res = word;
    for (int i = 0; i < BYTES; i++) begin
      res[i*8 +: 8] = (lane == IW'(i)) ? data : word[i*8 +: 8];
    end
    return res;
  endfunction

  state_t                 r_state;
  logic [15:0]            r_len;
  logic [16:0]            r_count;
  logic [IW-1:0]          r_idx;
  logic [TAM_PALABRA-1:0] r_word;
  logic                   r_ready;
  logic                   r_wr_en;
  logic [AW-1:0]          r_wr_addr;
  logic [TAM_PALABRA-1:0] r_wr_data;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_error;

  logic                   w_xfer;
  logic                   w_last_word;
  logic [TAM_PALABRA-1:0] w_word;

  assign w_xfer      = bus.BYTE_VALID & r_ready;
  assign w_last_word = ((r_count + 17'd1) == {1'b0, r_len});
  assign w_word      = put_byte(r_word, r_idx, bus.BYTE_IN);

  // Load sequencer; every output is a register updated alongside the state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state   <= S_IDLE;
      r_len     <= 16'd0;
      r_count   <= 17'd0;
      r_idx     <= '0;
      r_word    <= '0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wr_en <= 1'b0;
          r_ready <= 1'b0;
          if (bus.START) begin
            r_state <= S_LEN_LO;
            r_ready <= 1'b1;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_len   <= 16'd0;
            r_count <= 17'd0;
            r_idx   <= '0;
            r_word  <= '0;
          end
        end
        S_LEN_LO: begin
          if (w_xfer) begin
            r_len[7:0] <= bus.BYTE_IN;
            r_state    <= S_LEN_HI;
          end
        end
        S_LEN_HI: begin
          if (w_xfer) begin
            r_len[15:8] <= bus.BYTE_IN;
            r_ready     <= 1'b0;
            r_state     <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_len == 16'd0) begin
            r_state <= S_FINISH;
          end else if ({1'b0, r_len} > MAX_N) begin
            r_state <= S_ERR;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_xfer) begin
            r_word <= w_word;
            if (r_idx == LAST_IDX) begin
              // Ready drops together with the strobe so no byte lands during the write cycle.
              r_ready   <= 1'b0;
              r_wr_en   <= 1'b1;
              r_wr_data <= w_word;
              r_wr_addr <= r_count[AW-1:0];
              r_idx     <= '0;
              r_state   <= S_WRITE;
            end else begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        S_WRITE: begin
          r_wr_en <= 1'b0;
          r_count <= r_count + 17'd1;
          if (w_last_word) begin
            r_state <= S_FINISH;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_DATA;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        S_ERR: begin
          r_error <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_wr_en <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.BYTE_READY = r_ready;
  assign bus.WR_EN      = r_wr_en;
  assign bus.WR_ADDRESS = r_wr_addr;
  assign bus.WR_DATA    = r_wr_data;
  assign bus.BUSY       = r_busy;
  assign bus.DONE       = r_done;
  assign bus.ERROR      = r_error;
endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected RAM writes are queued per image
// and popped by an independent write-port monitor.
module tb_imem_loader;
  localparam int TP    = 1024;
  localparam int TW    = 32;
  localparam int BYTES = TW / 8;
  localparam int AW    = $clog2(TP);

  typedef struct {
    logic [AW-1:0] addr;
    logic [TW-1:0] data;
  } wr_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  imem_loader_if #(.TAM_POSICIONES(TP), .TAM_PALABRA(TW)) bus ();

  imem_loader #(.TAM_POSICIONES(TP), .TAM_PALABRA(TW)) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int            n_cmp = 0;
  int            n_bad = 0;
  wr_t           exp_q[$];
  logic [7:0]    stream[$];
  logic [TW-1:0] img[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest outstanding expected write.
  always @(negedge CLK) begin
    wr_t e;
    if (!RESET && bus.WR_EN === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write",
                 bus.WR_ADDRESS, bus.WR_DATA);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.WR_ADDRESS), 64'(e.addr));
        check("wr_data", 64'(bus.WR_DATA), 64'(e.data));
      end
    end
  end

  // Reference model: header then words, little-endian; writes only for 1 <= n <= TP.
  task automatic build_model(input int n);
    wr_t w;
    stream.delete();
    stream.push_back(8'(n % 256));
    stream.push_back(8'(n / 256));
    if (n >= 1 && n <= TP) begin
      for (int i = 0; i < n; i++) begin
        w.addr = AW'(i);
        w.data = img[i];
        exp_q.push_back(w);
        for (int b = 0; b < BYTES; b++) stream.push_back(8'((img[i] >> (8 * b)) % 256));
      end
    end
  endtask

  task automatic send_stream(input int pct, input int lim, output bit ok);
    int  cnt;
    int  waited;
    bit  sent;
    ok  = 1'b1;
    cnt = (lim < 0 || lim > stream.size()) ? stream.size() : lim;
    for (int k = 0; k < cnt; k++) begin
      sent   = 1'b0;
      waited = 0;
      while (!sent) begin
        bus.BYTE_IN    = stream[k];
        bus.BYTE_VALID = ($urandom_range(99) < pct);
        @(negedge CLK);
        if (bus.BYTE_VALID && bus.BYTE_READY) sent = 1'b1;
        @(posedge CLK);
        #1;
        waited++;
        if (!sent && waited > 1000) begin
          n_cmp++;
          n_bad++;
          $display("FAIL byte_timeout: byte %0d not accepted after %0d cycles", k, waited);
          bus.BYTE_VALID = 1'b0;
          ok = 1'b0;
          return;
        end
      end
    end
    bus.BYTE_VALID = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge CLK);
    #1 bus.START = 1'b1;
    @(posedge CLK);
    #1 bus.START = 1'b0;
    check("busy_after_start", 64'(bus.BUSY), 64'd1);
  endtask

  task automatic do_load(input int n, input int pct);
    bit ok;
    int t;
    build_model(n);
    pulse_start();
    send_stream(pct, -1, ok);
    if (!ok) begin
      exp_q.delete();
      return;
    end
    if (n == 0 || n > TP) begin
      @(posedge CLK);
      #1 check("flag_early", 64'({bus.DONE, bus.ERROR}), 64'd0);
      @(posedge CLK);
      #1;
    end
    t = 0;
    while (bus.BUSY && t < 50) begin
      @(posedge CLK);
      #1 t++;
    end
    check("busy_end", 64'(bus.BUSY), 64'd0);
    check("done", 64'(bus.DONE), (n <= TP) ? 64'd1 : 64'd0);
    check("error", 64'(bus.ERROR), (n > TP) ? 64'd1 : 64'd0);
    check("writes_pending", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    // Trailing byte must not be accepted once the image is complete.
    bus.BYTE_IN    = 8'hA5;
    bus.BYTE_VALID = 1'b1;
    @(negedge CLK);
    check("ready_after_load", 64'(bus.BYTE_READY), 64'd0);
    @(posedge CLK);
    #1 bus.BYTE_VALID = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.BUSY, bus.DONE, bus.ERROR, bus.WR_EN, bus.BYTE_READY,
                     (bus.WR_ADDRESS != '0), (bus.WR_DATA != '0)}), 64'd0);
  endtask

  task automatic async_reset(input string name);
    @(negedge CLK);
    #2 RESET = 1'b1;
    #1 check_all_zero(name);
    exp_q.delete();
    @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  initial begin
    bit ok;
    int t;
    bus.START      = 1'b0;
    bus.BYTE_IN    = 8'h00;
    bus.BYTE_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1 check_all_zero("reset_state");
    RESET = 1'b0;

    img = '{32'h0000_0013, 32'h0050_00B3};
    do_load(2, 100);

    img.delete();
    do_load(0, 100);
    do_load(1025, 100);

    img = '{32'hCAFE_F00D};
    do_load(1, 50);

    // Abort after the first word of a 3-word image, then reload.
    img = '{32'h1111_2222, 32'h3333_4444, 32'h5555_6666};
    build_model(3);
    pulse_start();
    send_stream(100, 2 + BYTES, ok);
    t = 0;
    while (exp_q.size() > 2 && t < 20) begin
      @(posedge CLK);
      #1 t++;
    end
    check("first_word_written", 64'(exp_q.size()), 64'd2);
    async_reset("reset_mid_load");
    img = '{32'hDEAD_BEEF};
    do_load(1, 100);

    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 12);
      img.delete();
      for (int i = 0; i < n; i++) img.push_back($urandom);
      do_load(n, $urandom_range(30, 100));
    end

    img.delete();
    for (int i = 0; i < TP; i++) img.push_back($urandom);
    do_load(TP, 100);

    async_reset("reset_after_done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
